poly_wave_synth: RTL and testbench

- Parametrised polyphonic waveform generator with NUM_VOICES independent voices.
- Each voice has its own period, a waveform select (square/saw/triangle/sine) and an enable.
- A register-write handshake sits upstream: the SPI decode logic drives it.
- A registered summing mixer sits downstream and feeds the DAC output pins.
- Register updates are deferred to the voice's phase wrap, so notes change without glitches.

---
 rtl/synth_pkg.sv | 44 ++++
 rtl/wave_voice.sv | 123 ++++++++++++
 rtl/poly_wave_synth.sv | 83 ++++++++
 tb/tb_poly_wave_synth.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types, sizes and waveform shaping for the polyphonic waveform synth.
// Every voice uses a 6-bit phase; shape() maps a phase to a 6-bit sample.
package synth_pkg;

  localparam int unsigned PHASE_W   = 6;
  localparam int unsigned LUT_DEPTH = 64;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned WAVE_W    = 2;

  typedef enum logic [WAVE_W-1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_t;

  typedef logic [PHASE_W-1:0] phase_t;

  // round(31.5 + 31.5*sin(2*pi*k/64))
  localparam phase_t SINE_LUT [LUT_DEPTH] = '{
    6'd32, 6'd35, 6'd38, 6'd41, 6'd44, 6'd46, 6'd49, 6'd51,
    6'd54, 6'd56, 6'd58, 6'd59, 6'd61, 6'd62, 6'd62, 6'd63,
    6'd63, 6'd63, 6'd62, 6'd62, 6'd61, 6'd59, 6'd58, 6'd56,
    6'd54, 6'd51, 6'd49, 6'd46, 6'd44, 6'd41, 6'd38, 6'd35,
    6'd32, 6'd28, 6'd25, 6'd22, 6'd19, 6'd17, 6'd14, 6'd12,
    6'd9,  6'd7,  6'd5,  6'd4,  6'd2,  6'd1,  6'd1,  6'd0,
    6'd0,  6'd0,  6'd1,  6'd1,  6'd2,  6'd4,  6'd5,  6'd7,
    6'd9,  6'd12, 6'd14, 6'd17, 6'd19, 6'd22, 6'd25, 6'd28
  };

  function automatic phase_t shape(input wave_t wave, input phase_t phase);
    phase_t w6;
    w6 = '0;
    case (wave)
      WAVE_SQUARE: w6 = phase[PHASE_W-1] ? '1 : '0;
      WAVE_SAW:    w6 = phase;
      WAVE_TRI:    w6 = phase[PHASE_W-1] ? {~phase[PHASE_W-2:0], 1'b0}
                                         : {phase[PHASE_W-2:0], 1'b0};
      WAVE_SINE:   w6 = SINE_LUT[phase];
    endcase
    return w6;
  endfunction

endpackage

// File: rtl/wave_voice.sv
// One synth voice: shadow/pending register set, clock divider, 6-bit phase
// accumulator and registered sample output.
module wave_voice
  import synth_pkg::*;
#(
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned AMP_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  logic [PERIOD_W-1:0] wr_period_i,
  input  wave_t               wr_wave_i,
  input  logic                wr_enable_i,
  output logic                pending_o,
  output logic                active_c_o,
  output logic [AMP_W-1:0]    sample_o
);

  localparam int unsigned SHIFT = PHASE_W - AMP_W;

  logic [PERIOD_W-1:0] period_q, period_d;
  wave_t               wave_q, wave_d;
  logic                enable_q, enable_d;
  logic [PERIOD_W-1:0] sh_period_q, sh_period_d;
  wave_t               sh_wave_q, sh_wave_d;
  logic                sh_enable_q, sh_enable_d;
  logic                pending_q, pending_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  phase_t              phase_q, phase_d;
  logic [AMP_W-1:0]    sample_q, sample_d;

  logic [PERIOD_W-1:0] step;
  logic                active;
  logic                tick;
  logic                wrap_tick;
  logic                apply;

  // Divider timing; a pending update lands when idle or exactly at the wrap.
  always_comb begin
    step      = period_q >> PHASE_W;
    active    = enable_q && (step != '0);
    tick      = active && (cnt_q == (step - PERIOD_W'(1)));
    wrap_tick = tick && (phase_q == '1);
    apply     = pending_q && (!active || wrap_tick);
  end

  always_comb begin
    period_d    = period_q;
    wave_d      = wave_q;
    enable_d    = enable_q;
    sh_period_d = sh_period_q;
    sh_wave_d   = sh_wave_q;
    sh_enable_d = sh_enable_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    sample_d    = '0;

    if (apply) begin
      period_d = sh_period_q;
      wave_d   = sh_wave_q;
      enable_d = sh_enable_q;
      cnt_d    = '0;
      phase_d  = '0;
    end else if (active) begin
      if (tick) begin
        cnt_d   = '0;
        phase_d = phase_q + PHASE_W'(1);
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end else begin
      cnt_d   = '0;
      phase_d = '0;
    end

    // A fresh write re-arms pending even if an apply clears it this cycle.
    if (wr_en_i) begin
      sh_period_d = wr_period_i;
      sh_wave_d   = wr_wave_i;
      sh_enable_d = wr_enable_i;
      pending_d   = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end

    if (active) begin
      sample_d = AMP_W'(shape(wave_q, phase_q) >> SHIFT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q    <= '0;
      wave_q      <= WAVE_SQUARE;
      enable_q    <= 1'b0;
      sh_period_q <= '0;
      sh_wave_q   <= WAVE_SQUARE;
      sh_enable_q <= 1'b0;
      pending_q   <= 1'b0;
      cnt_q       <= '0;
      phase_q     <= '0;
      sample_q    <= '0;
    end else begin
      period_q    <= period_d;
      wave_q      <= wave_d;
      enable_q    <= enable_d;
      sh_period_q <= sh_period_d;
      sh_wave_q   <= sh_wave_d;
      sh_enable_q <= sh_enable_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      sample_q    <= sample_d;
    end
  end

  assign pending_o  = pending_q;
  assign active_c_o = active;
  assign sample_o   = sample_q;

endmodule

// File: rtl/poly_wave_synth.sv
// Polyphonic waveform generator: register-write decode, per-voice generators
// and a registered summing mixer with active-voice count.
module poly_wave_synth
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned PERIOD_W   = 32,
  parameter int unsigned AMP_W      = 4,
  localparam int unsigned CNT_W     = $clog2(NUM_VOICES + 1),
  localparam int unsigned MIX_W     = AMP_W + CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [WAVE_W-1:0]   wr_wave,
  input  logic                wr_enable,
  output logic [MIX_W-1:0]    mix_out,
  output logic [CNT_W-1:0]    mix_active
);

  localparam int unsigned ADDR_SPACE = 1 << ADDR_W;

  logic [NUM_VOICES-1:0] pending;
  logic [NUM_VOICES-1:0] active;
  logic [NUM_VOICES-1:0] wr_en;
  logic [AMP_W-1:0]      sample [NUM_VOICES];
  logic [ADDR_SPACE-1:0] pending_pad;
  logic                  wr_fire;

  logic [MIX_W-1:0] mix_q, mix_d;
  logic [CNT_W-1:0] act_cnt_q, act_cnt_d;

  // Unused addresses read as not-pending, so writes there are swallowed.
  assign pending_pad = ADDR_SPACE'(pending);
  assign wr_ready    = !pending_pad[wr_addr];
  assign wr_fire     = wr_valid && wr_ready;

  for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice
    assign wr_en[gv] = wr_fire && (wr_addr == ADDR_W'(gv));

    wave_voice #(
      .PERIOD_W (PERIOD_W),
      .AMP_W    (AMP_W)
    ) u_voice (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (wr_en[gv]),
      .wr_period_i (wr_period),
      .wr_wave_i   (wave_t'(wr_wave)),
      .wr_enable_i (wr_enable),
      .pending_o   (pending[gv]),
      .active_c_o  (active[gv]),
      .sample_o    (sample[gv])
    );
  end

  // Mixer: sum of samples and popcount of active voices.
  always_comb begin
    mix_d     = '0;
    act_cnt_d = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      mix_d     = mix_d + MIX_W'(sample[v]);
      act_cnt_d = act_cnt_d + CNT_W'(active[v]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_q     <= '0;
      act_cnt_q <= '0;
    end else begin
      mix_q     <= mix_d;
      act_cnt_q <= act_cnt_d;
    end
  end

  assign mix_out    = mix_q;
  assign mix_active = act_cnt_q;

endmodule

// File: tb/tb_poly_wave_synth.sv
// Scoreboard bench for poly_wave_synth: a time-based voice model predicts the
// mixer outputs per cycle; a negedge monitor pops and compares.
module tb_poly_wave_synth;

  localparam int NV    = 3;
  localparam int PW    = 32;
  localparam int AW    = 4;
  localparam int CNT_W = $clog2(NV + 1);
  localparam int MIX_W = AW + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [2:0]       wr_addr = 3'd0;
  logic [PW-1:0]    wr_period = '0;
  logic [1:0]       wr_wave = 2'd0;
  logic             wr_enable = 1'b0;
  logic [MIX_W-1:0] mix_out;
  logic [CNT_W-1:0] mix_active;

  always #5 clk = ~clk;

  poly_wave_synth #(
    .NUM_VOICES (NV),
    .PERIOD_W   (PW),
    .AMP_W      (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_period  (wr_period),
    .wr_wave    (wr_wave),
    .wr_enable  (wr_enable),
    .mix_out    (mix_out),
    .mix_active (mix_active)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference waveform values computed directly from the waveform definitions
  function automatic int tb_sine(input int k);
    real x;
    x = 31.5 + 31.5 * $sin(2.0 * 3.14159265358979 * k / 64.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic int tb_shape(input int wave, input int ph);
    case (wave)
      0:       return (ph >= 32) ? 63 : 0;
      1:       return ph;
      2:       return (ph < 32) ? 2 * ph : 2 * (63 - ph);
      default: return tb_sine(ph);
    endcase
  endfunction

  // Voice model: t counts cycles elapsed inside the current waveform cycle
  longint m_period [NV];
  int     m_wave   [NV];
  bit     m_en     [NV];
  longint s_period [NV];
  int     s_wave   [NV];
  bit     s_en     [NV];
  bit     m_pend   [NV];
  longint m_t      [NV];
  int     samp_prev;

  typedef struct packed {
    logic [31:0] mix;
    logic [31:0] act;
  } exp_t;
  exp_t exp_q [$];

  function automatic bit m_active(input int v);
    return m_en[v] && ((m_period[v] / 64) != 0);
  endfunction

  function automatic int m_phase(input int v);
    longint step;
    step = m_period[v] / 64;
    return int'((m_t[v] / step) % 64);
  endfunction

  function automatic bit m_ready(input logic [2:0] a);
    if (int'(a) >= NV) return 1'b1;
    return !m_pend[int'(a)];
  endfunction

  int     mod_sum, mod_cnt;
  bit     mod_rdy, mod_act, mod_wrap, mod_fire, mod_apply;
  longint mod_step;
  exp_t   mod_e;

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) begin
        m_period[v] = 0; m_wave[v] = 0; m_en[v] = 0;
        s_period[v] = 0; s_wave[v] = 0; s_en[v] = 0;
        m_pend[v] = 0; m_t[v] = 0;
      end
      samp_prev = 0;
      exp_q.delete();
    end else begin
      mod_sum = 0;
      mod_cnt = 0;
      for (int v = 0; v < NV; v++) begin
        if (m_active(v)) begin
          mod_cnt++;
          mod_sum += tb_shape(m_wave[v], m_phase(v)) >> (6 - AW);
        end
      end
      mod_e.mix = 32'(samp_prev);
      mod_e.act = 32'(mod_cnt);
      exp_q.push_back(mod_e);
      samp_prev = mod_sum;
      mod_rdy = m_ready(wr_addr);
      for (int v = 0; v < NV; v++) begin
        mod_step  = m_period[v] / 64;
        mod_act   = m_active(v);
        mod_wrap  = mod_act && (m_t[v] + 1 == 64 * mod_step);
        mod_fire  = wr_valid && mod_rdy && (int'(wr_addr) == v);
        mod_apply = m_pend[v] && (!mod_act || mod_wrap);
        if (mod_apply) begin
          m_period[v] = s_period[v];
          m_wave[v]   = s_wave[v];
          m_en[v]     = s_en[v];
          m_t[v]      = 0;
        end else if (mod_act) begin
          m_t[v] = (m_t[v] + 1) % (64 * mod_step);
        end else begin
          m_t[v] = 0;
        end
        if (mod_fire) begin
          s_period[v] = longint'(wr_period);
          s_wave[v]   = int'(wr_wave);
          s_en[v]     = wr_enable;
          m_pend[v]   = 1'b1;
        end else if (mod_apply) begin
          m_pend[v] = 1'b0;
        end
      end
    end
  end

  exp_t mon_e;

  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      check("rst_mix_out", 32'(mix_out), 0);
      check("rst_mix_active", 32'(mix_active), 0);
      check("rst_wr_ready", 32'(wr_ready), 1);
    end else begin
      check("wr_ready", 32'(wr_ready), 32'(m_ready(wr_addr)));
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("mix_out", 32'(mix_out), mon_e.mix);
        check("mix_active", 32'(mix_active), mon_e.act);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_write(input int a, input longint p, input int w, input bit e);
    int n;
    n = 0;
    wr_addr   = 3'(a);
    wr_period = PW'(p);
    wr_wave   = 2'(w);
    wr_enable = e;
    wr_valid  = 1'b1;
    #1;
    while (!wr_ready && n < 20000) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (!wr_ready) begin
      errors++;
      $display("FAIL write_timeout addr %0d: got wr_ready=0 expected 1 within 20000 cycles", a);
    end
    @(posedge clk);
    #2;
    wr_valid = 1'b0;
  endtask

  int periods [8] = '{0, 32, 64, 128, 200, 256, 320, 448};

  initial begin : stim
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(100);

    do_write(0, 128, 0, 1'b1);          // square, applies immediately
    idle(300);
    do_write(0, 64, 2, 1'b1);           // triangle, waits for wrap
    idle(200);
    do_write(0, 64, 3, 1'b1);           // sine
    idle(200);
    do_write(0, 6400, 0, 1'b1);
    idle(100);
    do_write(0, 128, 1, 1'b1);          // held pending until the long wrap
    check("pend_ready_a0", 32'(wr_ready), 0);
    for (int i = 0; i < 20; i++) begin
      wr_addr = 3'(i % 2);
      #1;
      check("pend_ready_toggle", 32'(wr_ready), (i % 2 == 0) ? 0 : 1);
      @(posedge clk);
      #2;
    end
    wr_addr = 3'd0;
    idle(6500);

    for (int v = 0; v < NV; v++) do_write(v, 128, 0, 1'b1);
    idle(300);
    do_write(2, 128, 0, 1'b0);          // drop voice 2 at its wrap
    idle(300);
    do_write(7, 256, 1, 1'b1);          // out-of-range address
    idle(50);
    do_write(1, 32, 0, 1'b1);           // step 0: voice goes inactive
    idle(300);

    #1 rst_n = 1'b0;                     // mid-waveform async reset
    #1;
    check("async_rst_mix_out", 32'(mix_out), 0);
    check("async_rst_mix_active", 32'(mix_active), 0);
    check("async_rst_wr_ready", 32'(wr_ready), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(20);

    for (int i = 0; i < 40; i++) begin
      do_write(int'($urandom_range(0, 7)),
               longint'(periods[$urandom_range(0, 7)]) + longint'($urandom_range(0, 63)),
               int'($urandom_range(0, 3)),
               bit'($urandom_range(0, 3) != 0));
      idle(int'($urandom_range(0, 250)));
    end

    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2000000");
    $fatal(1, "watchdog expired");
  end

endmodule
